serial_subtracter_ctrl: RTL and testbench

//   Sequencer for a bit-serial multi-bit subtracter built on one full-subtracter cell.

---
 rtl/serial_subtracter_ctrl.sv | 91 +++++++++
 tb/tb_serial_subtracter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtracter_ctrl.sv
// Bit-serial subtracter sequencer: one full-subtracter step per clock, LSB first.
// WIDTH clocks in RUN, one DONE pulse; start is ignored unless IDLE.
module serial_subtracter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             br;
    logic [CW-1:0]    count;
    logic             bit_d, br_nxt, last_bit;

    always_comb begin
        bit_d    = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
        last_bit = (count == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The minuend register doubles as the result register: each processed
    // operand bit leaves at the LSB while its difference bit enters at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            br         <= 1'b0;
            count      <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= borrow_in;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= {bit_d, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    br    <= br_nxt;
                    count <= last_bit ? '0 : count + CW'(1);
                    if (last_bit) begin
                        difference <= {bit_d, a_sh[WIDTH-1:1]};
                        borrow_out <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtracter_ctrl.sv
// Randomized and directed checks of serial_subtracter_ctrl against an arithmetic model.
module tb_serial_subtracter_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         borrow_in;
    logic         busy, done;
    logic [W-1:0] difference;
    logic         borrow_out;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ops = 0;
    int cyc = 0;

    serial_subtracter_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy), .done(done), .difference(difference), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {borrow, difference} from plain integer subtraction
    function automatic logic [W:0] model(input int ua, input int ub, input int ubin);
        int r;
        r = ua - ub - ubin;
        return {(r < 0) ? 1'b1 : 1'b0, W'(r)};
    endfunction

    // Called just after the accepting edge; waits for done and checks result.
    task automatic wait_result(input logic [W:0] e, input bit timing);
        int  nb;
        bit  seen;
        nb   = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                if (timing) begin
                    check("latency", k - 1, W);
                    check("busy_cycles", nb, W);
                end
                check("difference", difference, e[W-1:0]);
                check("borrow_out", borrow_out, e[W]);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        if (timing) begin
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("result_held", difference, e[W-1:0]);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] sb,
                          input logic tbin, input bit timing);
        logic [W:0] e;
        e = model(ta, sb, tbin);
        @(negedge clk);
        a = ta; b = sb; borrow_in = tbin; start = 1'b1;
        @(posedge clk);
        ops++;
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        wait_result(e, timing);
    endtask

    logic [W-1:0] corners [5];
    int           t_done [3];
    int           nd;
    int           dc0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_difference", difference, 0);
        check("rst_borrow", borrow_out, 0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1'b1);
        run_op(8'h03, 8'h05, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b1);

        // start pulse mid-run must be ignored; previous result held through RUN
        @(negedge clk);
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        ops++;
        #1 start = 1'b0;
        dc0 = done_cnt;
        repeat (3) @(negedge clk);
        check("hold_in_run", difference, 8'h7F);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("single_done", done_cnt - dc0, 1);
        check("ignored_start_diff", difference, 8'h02);
        check("ignored_start_busy", busy, 0);

        // start held high: back-to-back ops every W+2 clocks
        @(negedge clk);
        a = 8'h20; b = 8'h0F; borrow_in = 1'b0; start = 1'b1;
        nd = 0;
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = cyc;
                nd++;
                check("held_diff", difference, 8'h11);
                if (nd == 3) start = 1'b0;
            end
        end
        ops += 3;
        check("held_done_count", nd, 3);
        if (nd == 3) begin
            check("held_period1", t_done[1] - t_done[0], W + 2);
            check("held_period2", t_done[2] - t_done[1], W + 2);
        end

        // reset mid-run
        @(negedge clk);
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc0 = done_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_difference", difference, 0);
        check("abort_borrow", borrow_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);
        check("abort_idle", busy, 0);
        run_op(8'h09, 8'h04, 1'b0, 1'b1);

        // start high across reset release is taken at the first edge with rst low
        @(negedge clk);
        rst = 1'b1; a = 8'h01; b = 8'h02; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        ops++;
        #1 start = 1'b0;
        check("rst_release_busy", busy, 1);
        wait_result(model(1, 2, 0), 1'b1);

        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int c = 0; c < 2; c++)
                    run_op(corners[i], corners[j], c[0], 1'b1);

        for (int i = 0; i < 2000; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        repeat (3) @(negedge clk);
        check("done_count", done_cnt, ops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
